// File: rtl/tl_bus_pkg.sv
// Shared types and the round-robin pick function for the TL bus arbiter family.
// The pick function is unrolled at elaboration, so num_in must be a constant at each call site.
package tl_bus_pkg;

   localparam int MAX_IN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   // One-hot pick of the first requester after last_grant, wrapping modulo num_in.
   function automatic logic [MAX_IN-1:0] rr_pick(input logic [MAX_IN-1:0] req,
                                                input int unsigned       last_grant,
                                                input int unsigned       num_in);
      logic [MAX_IN-1:0] pick;
      logic              found;
      int unsigned       idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_IN; k++) begin
         idx = (last_grant + k) % num_in;
         if (!found && (k <= num_in) && req[idx[4:0]]) begin
            pick[idx[4:0]] = 1'b1;
            found          = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational round-robin one-hot selector; zero latency, no flow control of its own.
// Produces an all-zero grant when no request bit is set.
module tl_rr_picker
   import tl_bus_pkg::*;
#(
   parameter int NUM_IN = 2,
   parameter int LG_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [LG_W-1:0]   last_grant,
   output logic [NUM_IN-1:0] grant_oh,
   output logic [LG_W-1:0]   grant_idx
);

   always_comb begin
      grant_oh = NUM_IN'(rr_pick(MAX_IN'(req), 32'(last_grant), 32'(NUM_IN)));
   end

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_oh[i]) grant_idx = LG_W'(i);
      end
   end

endmodule

// File: rtl/tl_bus_arbiter.sv
// Round-robin grant for the TL bus mux; 1 cycle request->io_choseOH, grant held through burst
// (stalls while io_out_ready low) and response; optional TL_BUS_ARB_STATS_EN adds grant counters.
module tl_bus_arbiter
   import tl_bus_pkg::*;
#(
   parameter int NUM_IN    = 2,
   parameter int WAIT_RESP = 1,
   parameter int CNT_W     = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_IN-1:0]       io_req_valid,
   input  logic [NUM_IN-1:0]       io_req_last,
   input  logic                    io_out_ready,
   input  logic                    io_resp_valid,
   input  logic                    io_resp_last,
   output logic [NUM_IN-1:0]       io_choseOH,
   output logic                    io_busy
`ifdef TL_BUS_ARB_STATS_EN
   ,
   output logic [NUM_IN*CNT_W-1:0] io_grant_cnt
`endif
);

   localparam int LG_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   state_t            state;
   logic [LG_W-1:0]   last_grant;
   logic [NUM_IN-1:0] pick_oh;
   logic [LG_W-1:0]   pick_idx;
   logic              req_fire_last;

   tl_rr_picker #(
      .NUM_IN (NUM_IN),
      .LG_W   (LG_W)
   ) u_picker (
      .req        (io_req_valid),
      .last_grant (last_grant),
      .grant_oh   (pick_oh),
      .grant_idx  (pick_idx)
   );

   // last_grant doubles as the index of the current owner while not IDLE.
   assign req_fire_last = io_out_ready & io_req_valid[last_grant] & io_req_last[last_grant];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         io_choseOH <= '0;
         io_busy    <= 1'b0;
         last_grant <= LG_W'(NUM_IN - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|io_req_valid) begin
                  io_choseOH <= pick_oh;
                  last_grant <= pick_idx;
                  io_busy    <= 1'b1;
                  state      <= DATA;
               end
            end
            DATA: begin
               if (req_fire_last) begin
                  if (WAIT_RESP != 0) begin
                     state <= RESP;
                  end else begin
                     state      <= IDLE;
                     io_choseOH <= '0;
                     io_busy    <= 1'b0;
                  end
               end
            end
            RESP: begin
               if (io_resp_valid && io_resp_last) begin
                  state      <= IDLE;
                  io_choseOH <= '0;
                  io_busy    <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               io_choseOH <= '0;
               io_busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef TL_BUS_ARB_STATS_EN
   logic [CNT_W-1:0] grant_cnt [NUM_IN];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_IN; i++) grant_cnt[i] <= '0;
      end else if (state == IDLE && |io_req_valid) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (pick_oh[i] && grant_cnt[i] != {CNT_W{1'b1}}) begin
               grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      io_grant_cnt = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         io_grant_cnt[i*CNT_W +: CNT_W] = grant_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Directed bench for tl_bus_arbiter: a WAIT_RESP=1 instance and a WAIT_RESP=0 instance share stimulus.
// Counter checks are compiled only when TL_BUS_ARB_STATS_EN is defined.
module tb_tl_bus_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] req_valid = '0;
   logic [1:0] req_last = '0;
   logic       out_ready = 1'b0;
   logic       resp_valid = 1'b0;
   logic       resp_last = 1'b0;
   logic [1:0] chose, chose0;
   logic       busy, busy0;
`ifdef TL_BUS_ARB_STATS_EN
   logic [7:0] cnt, cnt0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   tl_bus_arbiter #(.NUM_IN(2), .WAIT_RESP(1), .CNT_W(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .io_req_valid  (req_valid),
      .io_req_last   (req_last),
      .io_out_ready  (out_ready),
      .io_resp_valid (resp_valid),
      .io_resp_last  (resp_last),
      .io_choseOH    (chose),
      .io_busy       (busy)
`ifdef TL_BUS_ARB_STATS_EN
      ,
      .io_grant_cnt  (cnt)
`endif
   );

   tl_bus_arbiter #(.NUM_IN(2), .WAIT_RESP(0), .CNT_W(4)) dut0 (
      .clock         (clock),
      .reset         (reset),
      .io_req_valid  (req_valid),
      .io_req_last   (req_last),
      .io_out_ready  (out_ready),
      .io_resp_valid (resp_valid),
      .io_resp_last  (resp_last),
      .io_choseOH    (chose0),
      .io_busy       (busy0)
`ifdef TL_BUS_ARB_STATS_EN
      ,
      .io_grant_cnt  (cnt0)
`endif
   );

   // Grant must be one-hot or zero on every cycle.
   always @(negedge clock) begin
      checks++;
      if (((chose & (chose - 2'd1)) != 2'd0) || ((chose0 & (chose0 - 2'd1)) != 2'd0)) begin
         errors++;
         $display("FAIL onehot: choseOH=%b choseOH(wr0)=%b, required one-hot or zero", chose, chose0);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid  = '0;
      req_last   = '0;
      out_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_last  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      #3;
      checks++;
      if (chose !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: choseOH=%b busy=%b, required 00/0", chose, busy);
      end
      checks++;
      if (chose0 !== 2'b00 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_wr0: choseOH=%b busy=%b, required 00/0", chose0, busy0);
      end
      step();
      reset = 1'b1;
      step();
      checks++;
      if (chose !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: choseOH=%b busy=%b, required 00/0", chose, busy);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 2'b01;
      req_last  = 2'b01;
      out_ready = 1'b1;
      step();
      checks++;
      if (chose !== 2'b01 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: choseOH=%b busy=%b, required 01/1", chose, busy);
      end
      step();
      checks++;
      if (chose !== 2'b01 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_resp_wait: choseOH=%b busy=%b, required 01/1", chose, busy);
      end
      req_valid  = 2'b00;
      resp_valid = 1'b1;
      resp_last  = 1'b0;
      step();
      checks++;
      if (chose !== 2'b01) begin
         errors++;
         $display("FAIL single_resp_nolast: choseOH=%b, required 01", chose);
      end
      resp_last = 1'b1;
      step();
      checks++;
      if (chose !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_release: choseOH=%b busy=%b, required 00/0", chose, busy);
      end
      idle_inputs();
   endtask

   task automatic test_contention();
      logic [1:0] exp_c [10];
      exp_c = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
      do_reset();
      req_valid  = 2'b11;
      req_last   = 2'b11;
      out_ready  = 1'b1;
      resp_valid = 1'b1;
      resp_last  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (chose !== exp_c[i] || busy !== (exp_c[i] != 2'b00)) begin
            errors++;
            $display("FAIL contention[%0d]: choseOH=%b busy=%b, required %b/%b",
                     i, chose, busy, exp_c[i], (exp_c[i] != 2'b00));
         end
      end
      idle_inputs();
   endtask

   task automatic test_burst_lock();
      logic rdy [6];
      logic lst [6];
      rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      req_valid = 2'b11;
      req_last  = 2'b10;
      out_ready = 1'b0;
      step();
      checks++;
      if (chose !== 2'b01) begin
         errors++;
         $display("FAIL burst_grant: choseOH=%b, required 01", chose);
      end
      for (int k = 0; k < 6; k++) begin
         out_ready = rdy[k];
         req_last  = {1'b1, lst[k]};
         step();
         checks++;
         if (chose !== 2'b01) begin
            errors++;
            $display("FAIL burst_hold[%0d]: choseOH=%b, required 01", k, chose);
         end
      end
      req_last   = 2'b10;
      out_ready  = 1'b1;
      resp_valid = 1'b1;
      resp_last  = 1'b1;
      step();
      checks++;
      if (chose !== 2'b00) begin
         errors++;
         $display("FAIL burst_release: choseOH=%b, required 00", chose);
      end
      resp_valid = 1'b0;
      step();
      checks++;
      if (chose !== 2'b10) begin
         errors++;
         $display("FAIL burst_next_owner: choseOH=%b, required 10", chose);
      end
      idle_inputs();
   endtask

   task automatic test_wait_resp0();
      do_reset();
      req_valid = 2'b01;
      req_last  = 2'b01;
      out_ready = 1'b1;
      step();
      checks++;
      if (chose0 !== 2'b01) begin
         errors++;
         $display("FAIL wr0_grant: choseOH=%b, required 01", chose0);
      end
      step();
      checks++;
      if (chose0 !== 2'b00 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL wr0_release: choseOH=%b busy=%b, required 00/0", chose0, busy0);
      end
      req_valid  = 2'b00;
      resp_valid = 1'b1;
      resp_last  = 1'b1;
      step();
      checks++;
      if (chose0 !== 2'b00 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL wr0_resp_in_idle: choseOH=%b busy=%b, required 00/0", chose0, busy0);
      end
      req_valid  = 2'b10;
      resp_valid = 1'b0;
      resp_last  = 1'b0;
      step();
      checks++;
      if (chose0 !== 2'b10) begin
         errors++;
         $display("FAIL wr0_regrant: choseOH=%b, required 10", chose0);
      end
      idle_inputs();
   endtask

   task automatic test_mid_reset();
      do_reset();
      req_valid = 2'b10;
      req_last  = 2'b00;
      out_ready = 1'b1;
      step();
      checks++;
      if (chose !== 2'b10) begin
         errors++;
         $display("FAIL midrst_grant: choseOH=%b, required 10", chose);
      end
      step();
      checks++;
      if (chose !== 2'b10) begin
         errors++;
         $display("FAIL midrst_hold: choseOH=%b, required 10", chose);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (chose !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async_clear: choseOH=%b busy=%b, required 00/0", chose, busy);
      end
      step();
      reset     = 1'b1;
      req_valid = 2'b11;
      step();
      checks++;
      if (chose !== 2'b01 || chose0 !== 2'b01) begin
         errors++;
         $display("FAIL midrst_first_winner: choseOH=%b choseOH(wr0)=%b, required 01/01", chose, chose0);
      end
      idle_inputs();
   endtask

`ifdef TL_BUS_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req_valid  = 2'b01;
      req_last   = 2'b01;
      out_ready  = 1'b1;
      resp_valid = 1'b1;
      resp_last  = 1'b1;
      repeat (9) step();
      checks++;
      if (cnt[3:0] !== 4'd3) begin
         errors++;
         $display("FAIL stats_count3: cnt0=%0d, required 3", cnt[3:0]);
      end
      repeat (51) step();
      checks++;
      if (cnt[3:0] !== 4'd15) begin
         errors++;
         $display("FAIL stats_saturate: cnt0=%0d, required 15", cnt[3:0]);
      end
      checks++;
      if (cnt[7:4] !== 4'd0) begin
         errors++;
         $display("FAIL stats_other: cnt1=%0d, required 0", cnt[7:4]);
      end
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_burst_lock();
      test_wait_resp0();
      test_mid_reset();
`ifdef TL_BUS_ARB_STATS_EN
      test_stats();
`endif
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
